// File: rtl/sonic_pkg.sv
// Shared constants for the ultrasonic sensor/sampler pair.
// Latency: none (constants and a combinational helper only).
// Backpressure: not applicable.
package sonic_pkg;

    localparam int unsigned CLK_HZ       = 100_000_000;
    // Echo counts at or above this mean "no target" (18.5 ms at CLK_HZ).
    localparam int unsigned MAX_ECHO_DEF = 1_850_000;
    // 225 / 2^17 mm per cycle: 343 m/s, round trip, 100 MHz clock.
    localparam int unsigned MM_MULT_DEF  = 225;
    localparam int unsigned MM_SHIFT_DEF = 17;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_WAIT_FIN = 3'd2;
    localparam logic [2:0] ST_ACCUM    = 3'd3;
    localparam logic [2:0] ST_CONVERT  = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    // Clamp a wide scaled distance into the 16-bit output range.
    function automatic logic [15:0] sat16(input logic [47:0] v);
        return (|v[47:16]) ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/sonic_mm_conv.sv
// Mean echo width to millimetres: sum>>AVG_LOG2, times MM_MULT, >>MM_SHIFT, saturate.
// Latency: purely combinational; the parent registers the result.
// Backpressure: none.
module sonic_mm_conv
    import sonic_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned MM_MULT  = MM_MULT_DEF,
    parameter int unsigned MM_SHIFT = MM_SHIFT_DEF
) (
    input  logic [32+AVG_LOG2-1:0] sum,
    output logic [15:0]            dist_mm
);

    logic [31:0] mean;
    logic [47:0] prod;
    logic [47:0] scaled;

    // Average, scale to mm and clamp to the 16-bit range.
    always_comb begin
        mean    = 32'(sum >> AVG_LOG2);
        prod    = 48'(mean) * 48'(MM_MULT);
        scaled  = prod >> MM_SHIFT;
        dist_mm = sat16(scaled);
    end

endmodule

// File: rtl/sonic_sampler.sv
// Periodically triggers sonic_sensor, averages 2**AVG_LOG2 echo counts, reports distance in mm.
// Latency: result registered two cycles after the finishing edge of the last sample.
// Backpressure: sens_req is held off while sens_busy is high; no output backpressure.
module sonic_sampler
    import sonic_pkg::*;
#(
    parameter int unsigned PERIOD_CYC  = 6_000_000,
    parameter int unsigned TIMEOUT_CYC = 2_500_000,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned MAX_ECHO    = MAX_ECHO_DEF,
    parameter int unsigned MM_MULT     = MM_MULT_DEF,
    parameter int unsigned MM_SHIFT    = MM_SHIFT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        sens_req,
    input  logic        sens_busy,
    input  logic        sens_finish,
    input  logic [31:0] sens_data,
    output logic [15:0] dist_mm,
    output logic        dist_valid,
    output logic        out_of_range,
    output logic        timeout_err
);

    localparam int unsigned SUM_W    = 32 + AVG_LOG2;
    localparam logic [4:0]  N_AVG    = 5'(1 << AVG_LOG2);
    localparam logic [31:0] PER_LAST = 32'(PERIOD_CYC - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] ECHO_LIM = 32'(MAX_ECHO);

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [31:0]      per_cnt;
    logic [31:0]      to_cnt;
    logic [31:0]      sample;
    logic [SUM_W-1:0] sum;
    logic [4:0]       cnt;
    logic             oor;
    logic             fin_q;
    logic             fin_edge;
    logic             per_done;
    logic             to_hit;
    logic [15:0]      conv_mm;

    // Only a low-to-high transition counts; a level already high on entry is ignored.
    assign fin_edge = sens_finish & ~fin_q;
    assign per_done = (per_cnt == PER_LAST);
    assign to_hit   = (to_cnt == TO_LAST);
    assign sens_req = (state == ST_REQ);

    sonic_mm_conv #(
        .AVG_LOG2 (AVG_LOG2),
        .MM_MULT  (MM_MULT),
        .MM_SHIFT (MM_SHIFT)
    ) u_conv (
        .sum     (sum),
        .dist_mm (conv_mm)
    );

    // Next-state selection; entry into REQ always requires the sensor to be idle.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:     if (enable && !sens_busy) nxt = ST_REQ;
            ST_REQ:      nxt = ST_WAIT_FIN;
            ST_WAIT_FIN: begin
                if (fin_edge)    nxt = ST_ACCUM;
                else if (to_hit) nxt = ST_GAP;
            end
            ST_ACCUM:    nxt = ((cnt + 5'd1) == N_AVG) ? ST_CONVERT : ST_GAP;
            ST_CONVERT:  nxt = ST_GAP;
            ST_GAP: begin
                if (per_done) begin
                    if (!enable)        nxt = ST_IDLE;
                    else if (!sens_busy) nxt = ST_REQ;
                end
            end
            default:     nxt = ST_IDLE;
        endcase
    end

    // State register plus period/timeout counters, both zero in the REQ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            per_cnt <= '0;
            to_cnt  <= '0;
            fin_q   <= 1'b0;
        end else begin
            state <= nxt;
            fin_q <= sens_finish;
            if (nxt == ST_REQ)  per_cnt <= '0;
            else if (!per_done) per_cnt <= per_cnt + 32'd1;
            if (nxt == ST_REQ)
                to_cnt <= '0;
            else if (state == ST_REQ || state == ST_WAIT_FIN)
                to_cnt <= to_cnt + 32'd1;
        end
    end

    // Sample capture, accumulation and result registers; pulses default low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample       <= '0;
            sum          <= '0;
            cnt          <= '0;
            oor          <= 1'b0;
            dist_mm      <= '0;
            dist_valid   <= 1'b0;
            out_of_range <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            dist_valid  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_WAIT_FIN: begin
                    if (fin_edge)    sample      <= sens_data;
                    else if (to_hit) timeout_err <= 1'b1;
                end
                ST_ACCUM: begin
                    sum <= sum + SUM_W'(sample);
                    cnt <= cnt + 5'd1;
                    if (sample >= ECHO_LIM) oor <= 1'b1;
                end
                ST_CONVERT: begin
                    dist_mm      <= conv_mm;
                    out_of_range <= oor;
                    dist_valid   <= 1'b1;
                    sum          <= '0;
                    cnt          <= '0;
                    oor          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
